pd_header_buffer: RTL

- Double-buffered, parametrised block-header store for the bitcoin miner datapath.
- USB/decoder side writes bytes into a shadow (load) bank while the hash core reads the active bank.
- A commit swaps the banks. The active bank's nonce field increments in place by a parametrised step, with full multi-byte carry and exhaustion detection.
- Sits between the USB byte decoder and the SHA-256 chunk scheduler.

---
 rtl/pd_hdr_pkg.sv | 27 ++
 rtl/pd_nonce_incr.sv | 40 ++++
 rtl/pd_header_buffer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pd_hdr_pkg.sv
// rtl/pd_hdr_pkg.sv - shared types and default layout for the block-header buffer
//
// Purpose: state encoding, byte type and default bank layout used by
//          pd_header_buffer and pd_nonce_incr.
// Contents:
//   state_t          - EMPTY / ACTIVE / EXHAUSTED / PENDING
//   byte_t           - one header byte
//   DEF_*            - default 112/64/16 layout, nonce at byte 76, 4 bytes, step 8
package pd_hdr_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    ACTIVE    = 2'd1,
    EXHAUSTED = 2'd2,
    PENDING   = 2'd3
  } state_t;

  typedef logic [7:0] byte_t;

  localparam int DEF_NUM_BYTES    = 112;
  localparam int DEF_CHUNK1_BYTES = 64;
  localparam int DEF_CHUNK2_BYTES = 16;
  localparam int DEF_NONCE_OFFSET = 76;
  localparam int DEF_NONCE_BYTES  = 4;
  localparam int DEF_NONCE_STEP   = 8;

endpackage

// File: rtl/pd_nonce_incr.sv
// rtl/pd_nonce_incr.sv - byte-wise little-endian nonce adder with carry-out
//
// Purpose: adds an 8-bit step to a NONCE_BYTES-wide little-endian value,
//          rippling the carry through every byte. Purely combinational.
// Ports:
//   bytes_in   in   [NONCE_BYTES-1:0][7:0]  current nonce, byte 0 = LSB
//   step       in   8                       value to add
//   bytes_out  out  [NONCE_BYTES-1:0][7:0]  (bytes_in + step) mod 2^(8*NONCE_BYTES)
//   carry_out  out  1                       addition overflowed the top byte
module pd_nonce_incr
  import pd_hdr_pkg::*;
#(
  parameter int NONCE_BYTES = DEF_NONCE_BYTES
) (
  input  logic [NONCE_BYTES-1:0][7:0] bytes_in,
  input  logic [7:0]                  step,
  output logic [NONCE_BYTES-1:0][7:0] bytes_out,
  output logic                        carry_out
);

  logic [8:0] sum;
  logic       carry;

  // Step only enters byte 0; higher bytes see just the rippled carry.
  always_comb begin
    bytes_out = '0;
    sum       = '0;
    carry     = 1'b0;
    for (int j = 0; j < NONCE_BYTES; j++) begin
      sum = {1'b0, bytes_in[j]} + {8'd0, carry};
      if (j == 0) begin
        sum = sum + {1'b0, step};
      end
      bytes_out[j] = sum[7:0];
      carry        = sum[8];
    end
    carry_out = carry;
  end

endmodule

// File: rtl/pd_header_buffer.sv
// rtl/pd_header_buffer.sv - double-buffered block-header store with in-place nonce increment
//
// Purpose: the decoder writes bytes into the load bank while the hash core reads
//          the active bank. A commit swaps the banks one edge later. The active
//          bank's nonce field is advanced by NONCE_STEP on each increment pulse,
//          and wrapping it marks the header exhausted.
// Optional build macro: PD_HDR_COMMIT_GUARD_EN
//   defined   - commit together with increment in ACTIVE goes through PENDING:
//               the increment is applied, then the swap happens one cycle later.
//   undefined - commit wins and the colliding increment is dropped.
// Ports:
//   clk                in   1   system clock, rising edge
//   rst                in   1   asynchronous active-high reset
//   i_data_en          in   1   byte write strobe to load bank
//   i_data             in   8   write byte
//   i_data_sel         in   ADDR_W  byte address in load bank
//   i_commit           in   1   load bank complete, request swap
//   increment          in   1   add NONCE_STEP to active nonce
//   o_load_ready       out  1   load bank may be written
//   o_hdr_valid        out  1   active bank holds a live header
//   o_nonce_exhausted  out  1   active nonce wrapped
//   o_bank             out  1   index of active bank
//   o_nonce            out  NONCE_BYTES*8  active nonce value
//   chunk_1            out  active bytes [CHUNK1_BYTES-1:0]
//   chunk_2            out  next CHUNK2_BYTES active bytes
//   difficulty         out  remaining active bytes
module pd_header_buffer
  import pd_hdr_pkg::*;
#(
  parameter int NUM_BYTES    = DEF_NUM_BYTES,
  parameter int CHUNK1_BYTES = DEF_CHUNK1_BYTES,
  parameter int CHUNK2_BYTES = DEF_CHUNK2_BYTES,
  parameter int NONCE_OFFSET = DEF_NONCE_OFFSET,
  parameter int NONCE_BYTES  = DEF_NONCE_BYTES,
  parameter int NONCE_STEP   = DEF_NONCE_STEP,
  parameter int ADDR_W       = $clog2(NUM_BYTES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_data_en,
  input  logic [7:0]                    i_data,
  input  logic [ADDR_W-1:0]             i_data_sel,
  input  logic                          i_commit,
  input  logic                          increment,
  output logic                          o_load_ready,
  output logic                          o_hdr_valid,
  output logic                          o_nonce_exhausted,
  output logic                          o_bank,
  output logic [NONCE_BYTES*8-1:0]      o_nonce,
  output logic [CHUNK1_BYTES-1:0][7:0]  chunk_1,
  output logic [CHUNK2_BYTES-1:0][7:0]  chunk_2,
  output logic [NUM_BYTES-CHUNK1_BYTES-CHUNK2_BYTES-1:0][7:0] difficulty
);

  state_t                   state;
  logic                     bank;
  logic                     load_ready;
  logic                     hdr_valid;
  logic                     nonce_exhausted;

  byte_t [NUM_BYTES-1:0]    bank0;
  byte_t [NUM_BYTES-1:0]    bank1;
  byte_t [NUM_BYTES-1:0]    active;
  logic  [NUM_BYTES-1:0]    we;

  byte_t [NONCE_BYTES-1:0]  nonce_cur;
  byte_t [NONCE_BYTES-1:0]  nonce_next;
  logic                     nonce_carry;
  logic                     inc_apply;
  logic                     sel_in_range;

  // Active bank view: every output is a plain slice of this, no extra latency.
  always_comb begin
    active = bank ? bank1 : bank0;
  end

  assign nonce_cur = active[NONCE_OFFSET +: NONCE_BYTES];

  pd_nonce_incr #(
    .NONCE_BYTES (NONCE_BYTES)
  ) u_nonce_incr (
    .bytes_in  (nonce_cur),
    .step      (8'(NONCE_STEP)),
    .bytes_out (nonce_next),
    .carry_out (nonce_carry)
  );

  // Fully decoded byte write enable into the load bank (the one not active).
  assign sel_in_range = ({1'b0, i_data_sel} < (ADDR_W+1)'(NUM_BYTES));

  always_comb begin
    we = '0;
    if (i_data_en && load_ready && sel_in_range) begin
      we[i_data_sel] = 1'b1;
    end
  end

  // Increments only touch the active bank while it is live. Without the guard,
  // a same-cycle commit wins and the increment is simply lost.
`ifdef PD_HDR_COMMIT_GUARD_EN
  assign inc_apply = (state == ACTIVE) && increment;
`else
  assign inc_apply = (state == ACTIVE) && increment && !i_commit;
`endif

  // Bank storage. Writes go to the load bank and increments to the active
  // bank, so the two never target the same byte in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (we[i]) begin
          if (bank) begin
            bank0[i] <= i_data;
          end else begin
            bank1[i] <= i_data;
          end
        end
      end
      if (inc_apply) begin
        for (int j = 0; j < NONCE_BYTES; j++) begin
          if (bank) begin
            bank1[NONCE_OFFSET+j] <= nonce_next[j];
          end else begin
            bank0[NONCE_OFFSET+j] <= nonce_next[j];
          end
        end
      end
    end
  end

  // Control FSM with registered flags. load_ready drops for the single cycle
  // after an accepted commit so the freshly swapped load bank is not written
  // while the decoder is still reacting to the swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= EMPTY;
      bank            <= 1'b0;
      load_ready      <= 1'b1;
      hdr_valid       <= 1'b0;
      nonce_exhausted <= 1'b0;
    end else begin
      load_ready <= 1'b1;
      case (state)
        EMPTY, EXHAUSTED: begin
          if (i_commit) begin
            bank            <= ~bank;
            state           <= ACTIVE;
            hdr_valid       <= 1'b1;
            nonce_exhausted <= 1'b0;
            load_ready      <= 1'b0;
          end
        end
        ACTIVE: begin
`ifdef PD_HDR_COMMIT_GUARD_EN
          // Increment is applied this edge; the swap follows from PENDING,
          // which discards any wrap since the bank is being retired anyway.
          if (i_commit && increment) begin
            state      <= PENDING;
            load_ready <= 1'b0;
          end else
`endif
          if (i_commit) begin
            bank       <= ~bank;
            load_ready <= 1'b0;
          end else if (inc_apply && nonce_carry) begin
            state           <= EXHAUSTED;
            hdr_valid       <= 1'b0;
            nonce_exhausted <= 1'b1;
          end
        end
        PENDING: begin
          bank  <= ~bank;
          state <= ACTIVE;
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  assign o_load_ready      = load_ready;
  assign o_hdr_valid       = hdr_valid;
  assign o_nonce_exhausted = nonce_exhausted;
  assign o_bank            = bank;
  assign o_nonce           = nonce_cur;
  assign chunk_1           = active[CHUNK1_BYTES-1:0];
  assign chunk_2           = active[CHUNK1_BYTES+CHUNK2_BYTES-1:CHUNK1_BYTES];
  assign difficulty        = active[NUM_BYTES-1:CHUNK1_BYTES+CHUNK2_BYTES];

endmodule
